// File: rtl/pipe_muldiv_unit.sv
// pipe_muldiv_unit: iterative signed/unsigned multiply/divide into HI/LO.
// Latency WIDTH+1 edges from accepted start to result (one bit per cycle + fix-up).
// Backpressure: busy stalls issue; start while busy is dropped; flush aborts with no result.
//
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   start, op          issue request (IDLE only); op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcA, srcB         multiplicand/dividend, multiplier/divisor (sampled at issue only)
//   flush              abort the in-flight op, HI/LO untouched
//   hi_we, lo_we,wdata direct HI/LO writes, honoured only while idle
//   busy, done         op in flight / one-cycle result pulse
//   hi, lo             result registers
module pipe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;   // negate product / quotient
  logic               neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [WIDTH-1:0]   m_q, m_d;               // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;         // {acc/remainder, multiplier/quotient}
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes; the most-negative value maps onto itself, which reads
  // correctly as an unsigned magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = ~op[0] & srcA[WIDTH-1];
  assign b_neg = ~op[0] & srcB[WIDTH-1];
  assign a_mag = a_neg ? -srcA : srcA;
  assign b_mag = b_neg ? -srcB : srcB;

  // Shift-add step: conditionally add into the upper half, then shift the
  // whole product right with the carry coming in at the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // Restoring step: bring the next dividend bit into the remainder and
  // subtract; the borrow bit says whether to keep the difference.
  logic [WIDTH:0]     div_tmp, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  assign div_tmp  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, m_q};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                     prod_q[WIDTH-2:0], div_ok};

  // Sign fix-up applied when the result is committed.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -prod_q : prod_q;
  assign quo_fix  = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    a_orig_d  = a_orig_q;
    m_d       = m_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          divz_d    = (srcB == '0);
          a_orig_d  = srcA;
          m_d       = op[1] ? b_mag : a_mag;
          prod_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end
      end
      S_RUN: begin
        prod_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (divz_q) begin
          hi_d = a_orig_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: leave HI/LO as they were before the op and suppress done.
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      a_orig_q  <= '0;
      m_q       <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      a_orig_q  <= a_orig_d;
      m_q       <= m_d;
      prod_q    <= prod_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Bench for pipe_muldiv_unit: WIDTH=32 instance checked every cycle against an
// arithmetic reference model, plus directed literal expectations; WIDTH=8
// instance checked with literal vectors only.
module tb_pipe_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit DUT
  logic        start = 0, flush = 0, hi_we = 0, lo_we = 0;
  logic [1:0]  op = 0;
  logic [31:0] srcA = 0, srcB = 0, wdata = 0;
  logic        busy, done;
  logic [31:0] hi, lo;

  pipe_muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // 8-bit DUT
  logic       start8 = 0, flush8 = 0, hi_we8 = 0, lo_we8 = 0;
  logic [1:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, wdata8 = 0;
  logic       busy8, done8;
  logic [7:0] hi8, lo8;

  pipe_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .srcA(a8), .srcB(b8),
    .flush(flush8), .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] mdu_ref(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Transaction-level model: an accepted op produces its result WIDTH+1 edges later.
  logic        m_busy = 0, m_done = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_res = 0;
  int          m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (flush) m_busy = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = m_res;
            m_done = 1; m_busy = 0;
          end
        end
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        if (start && !flush) begin
          m_res  = mdu_ref(op, srcA, srcB);
          m_busy = 1;
          m_left = 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cycle", {busy, done, hi, lo}, {m_busy, m_done, m_hi, m_lo});
      if (done) done_cnt++;
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srcA = a; srcB = b; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    chk({name, "_model"}, mdu_ref(o, a, b), exp);
    issue(o, a, b);
    chk({name, "_busy"}, busy, 1'b1);
    wait_done(lat);
    chk({name, "_lat"}, lat, 33);
    chk({name, "_res"}, {hi, lo}, exp);
    @(posedge clk); #1;
    chk({name, "_pulse"}, done, 1'b0);
  endtask

  task automatic run8(input string name, input logic [1:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    int lat;
    op8 = o; a8 = a; b8 = b; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    chk({name, "_lat"}, lat, 9);
    chk({name, "_res"}, {hi8, lo8}, exp);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset32", {busy, done, hi, lo}, 66'd0);
    chk("reset8", {busy8, done8, hi8, lo8}, 18'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd7, 64'h0000_0003_2492_4924);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
    run_op("div_zero", 2'b10, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // Preload, then abort a multiply part-way.
    hi_we = 1; wdata = 32'h11; @(posedge clk); #1;
    hi_we = 0; lo_we = 1; wdata = 32'h22; @(posedge clk); #1;
    lo_we = 0;
    base = done_cnt;
    issue(2'b01, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy", busy, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_nodone", done_cnt, base);
    chk("flush_keep", {hi, lo}, 64'h0000_0011_0000_0022);
    run_op("after_flush", 2'b01, 32'd7, 32'd9, 64'h0000_0000_0000_003F);

    // Flush and start together while idle: op must not be accepted.
    op = 2'b01; srcA = 3; srcB = 3; start = 1; flush = 1;
    @(posedge clk); #1;
    start = 0; flush = 0;
    chk("flush_start_busy", busy, 1'b0);

    // Direct write concurrent with an accepted start lands at T0, then gets overwritten.
    hi_we = 1; wdata = 32'hABCD;
    issue(2'b01, 32'd2, 32'd3);
    hi_we = 0;
    chk("we_at_t0", hi, 32'hABCD);
    begin
      int lat;
      wait_done(lat);
      chk("we_then_res", {hi, lo}, 64'h0000_0000_0000_0006);
    end

    // Second start and direct writes mid-op are ignored; operands may change.
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    repeat (5) @(posedge clk);
    #1 op = 2'b01; srcA = 1; srcB = 1; start = 1; hi_we = 1; lo_we = 1; wdata = 32'hDEAD;
    @(posedge clk); #1;
    start = 0; hi_we = 0; lo_we = 0;
    begin
      int lat;
      wait_done(lat);
      chk("midop_lat", lat, 27);
      chk("midop_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    end
    repeat (40) @(posedge clk);
    #1 chk("midop_idle", busy, 1'b0);

    // Async reset mid-op.
    base = done_cnt;
    issue(2'b01, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    #1 chk("arst_now", {busy, done, hi, lo}, 66'd0);
    #2 reset = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("arst_nodone", done_cnt, base);
    chk("arst_idle", {busy, hi, lo}, 65'd0);

    // WIDTH=8 instance.
    run8("w8_div", 2'b10, 8'h80, 8'd3, 16'hFED6);
    run8("w8_mult", 2'b00, 8'hFD, 8'd5, 16'hFFF1);
    run8("w8_divz", 2'b11, 8'd200, 8'd0, 16'hC8FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_muldiv_unit.md
Name: pipe_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the execute stage of the pipelined datapath. Width is set by WIDTH.
- Executes signed/unsigned MULT and DIV one bit per cycle into dedicated HI/LO registers.
- Raises `busy` so the hazard unit stalls dependent HI/LO reads and new MDU ops.
- Supports mid-operation abort via `flush`, for branch-mispredict or exception kill of the issuing instruction.

Parameters:
- WIDTH, 32, operand and HI/LO register width in bits. Must be at least 4. Iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  issue request, sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- srcA  input  WIDTH  multiplicand / dividend
- srcB  input  WIDTH  multiplier / divisor
- flush  input  1  abort any in-progress op
- hi_we  input  1  direct HI write (MTHI)
- lo_we  input  1  direct LO write (MTLO)
- wdata  input  WIDTH  data for hi_we/lo_we
- busy  output  1  high while an op is in flight (stall request)
- done  output  1  one-cycle pulse when HI/LO take a new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0. Reset mid-op discards the op with no done pulse.
- FSM states and transitions:
  - IDLE -> RUN on start && !flush.
  - RUN -> RUN while counter < WIDTH-1; RUN -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
  - Any state -> IDLE on flush.
- `busy` = (state != IDLE), registered.
- Latency: start sampled at edge T0.
  - busy=1 after T0.
  - WIDTH iterations at edges T1..T_WIDTH.
  - At edge T_{WIDTH+1}: hi/lo updated, done=1 for exactly one cycle, busy=0.
  - Total WIDTH+1 edges from start to result.
- At T0, latch op, sign flags, and magnitudes. Signed ops take the two's-complement absolute value of negative operands.
- MULT/MULTU:
  - Shift-add over the magnitudes, 2*WIDTH-bit product.
  - In FIX, negate the product if exactly one signed operand was negative.
  - hi = product[2W-1:W], lo = product[W-1:0].
- DIV/DIVU:
  - Restoring division, one quotient bit per iteration.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Divide by zero (srcB==0 at T0), any signedness: lo = all ones, hi = original srcA. Same latency, done pulses normally.
- Signed overflow (DIV, srcA = most-negative, srcB = -1): lo = most-negative, hi = 0.
- start while busy: ignored, no queueing. The hazard unit guarantees it is not issued.
- flush while RUN or FIX: return to IDLE next edge. hi/lo keep their pre-op values, no done. busy drops the cycle after the flush edge.
- flush and start in the same IDLE cycle: flush wins, op not accepted.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored while busy.
  - Concurrent with an accepted start: the write is applied at T0 and the op result later overwrites it.
  - hi_we and lo_we together write both registers.
- Operands are not re-sampled after T0; srcA/srcB may change freely during RUN.

Test Plan:
- MULTU srcA=srcB=0xFFFFFFFF (WIDTH=32) -> busy for 33 edges, done at T33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT srcA=0xFFFFFFFD (-3), srcB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via hi_we/lo_we, start MULTU 7*9, flush at T10 -> busy=0 after T11, no done, hi=0x11, lo=0x22. A new start then completes with lo=0x3F, hi=0.
- Second start and hi_we asserted mid-op -> both ignored, first result intact. Async reset at T5 -> immediate busy=0, hi=lo=0, no done.
- WIDTH=8 instance: DIV -128 / 3 -> lo=0xD6 (-42), hi=0xFE (-2), done at T9.
